// File: rtl/reg_mux_n.sv
// Registered N:1 mux with a one-deep valid/ready output stage, direct or round-robin scan selection.
// Optional sticky out-of-range select flag sel_err when MUX_SEL_ERR_EN is defined.
module reg_mux_n #(
    parameter int N = 5,
    parameter int W = 1,
    localparam int SW = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N*W-1:0] in_data,
    input  logic           in_vld,
    output logic           in_rdy,
    input  logic [SW-1:0]  sel,
    input  logic           mode,
    output logic [W-1:0]   out_data,
    output logic           out_vld,
    input  logic           out_rdy,
    output logic [SW-1:0]  cur_ch
`ifdef MUX_SEL_ERR_EN
    ,
    output logic           sel_err
`endif
);

    localparam logic [SW:0]   N_V   = (SW+1)'(N);
    localparam logic [SW-1:0] LAST  = SW'(N - 1);

    logic [SW-1:0] scan_ch;
    logic [SW-1:0] src;
    logic          space;
    logic          sel_ok;
    logic          accept;

    // Handshake: a word moves when valid and ready are both high on a rising edge;
    // in_rdy never looks at in_vld, and out_vld stays high until out_rdy consumes it.
    assign space  = !out_vld || out_rdy;
    assign sel_ok = mode || ({1'b0, sel} < N_V);
    assign in_rdy = space && sel_ok;
    assign accept = in_vld && in_rdy;
    assign src    = mode ? scan_ch : sel;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_data <= '0;
            out_vld  <= 1'b0;
            cur_ch   <= '0;
            scan_ch  <= '0;
        end else if (accept) begin
            out_data <= in_data[src*W +: W];
            cur_ch   <= src;
            out_vld  <= 1'b1;
            if (mode) begin
                scan_ch <= (scan_ch == LAST) ? '0 : scan_ch + 1'b1;
            end
        end else if (out_rdy) begin
            out_vld <= 1'b0;
        end
    end

`ifdef MUX_SEL_ERR_EN
    // Sticky until reset; observation only, never gates the datapath.
    always_ff @(posedge clk) begin
        if (rst) begin
            sel_err <= 1'b0;
        end else if (!mode && in_vld && ({1'b0, sel} >= N_V)) begin
            sel_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_reg_mux_n.sv
// Randomized and directed bench for reg_mux_n (N=5, W=8) against a queue-based transaction model.
module tb_reg_mux_n;
  localparam int N  = 5;
  localparam int W  = 8;
  localparam int SW = $clog2(N);

  logic           clk = 1'b0;
  logic           rst;
  logic [N*W-1:0] in_data;
  logic           in_vld;
  logic           in_rdy;
  logic [SW-1:0]  sel;
  logic           mode;
  logic [W-1:0]   out_data;
  logic           out_vld;
  logic           out_rdy;
  logic [SW-1:0]  cur_ch;
`ifdef MUX_SEL_ERR_EN
  logic           sel_err;
`endif

  int total = 0;
  int bad   = 0;

  // model state: pending words as {ch, data}, last presented word, scan position
  logic [SW+W-1:0] exp_q[$];
  logic [W-1:0]    last_data;
  logic [SW-1:0]   last_ch;
  int              scan_pos;
  logic            exp_err;

  reg_mux_n #(.N(N), .W(W)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_vld(in_vld), .in_rdy(in_rdy),
    .sel(sel), .mode(mode), .out_data(out_data), .out_vld(out_vld),
    .out_rdy(out_rdy), .cur_ch(cur_ch)
`ifdef MUX_SEL_ERR_EN
    , .sel_err(sel_err)
`endif
  );

  // clock / reset block
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".out_vld"}, 32'(out_vld), 32'(exp_q.size() != 0));
    check({tag, ".out_data"}, 32'(out_data), 32'(last_data));
    check({tag, ".cur_ch"}, 32'(cur_ch), 32'(last_ch));
`ifdef MUX_SEL_ERR_EN
    check({tag, ".sel_err"}, 32'(sel_err), 32'(exp_err));
`endif
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_vld = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    last_data = '0;
    last_ch = '0;
    scan_pos = 0;
    exp_err = 1'b0;
    check_outputs("reset");
  endtask

  // driver: present one cycle of inputs, check in_rdy, advance model and DUT by one edge
  task automatic step(input logic v, input logic md, input logic [SW-1:0] s, input logic ordy,
                      input string tag);
    int  ch;
    bit  exp_rdy;
    bit  acc;
    in_vld = v;
    mode = md;
    sel = s;
    out_rdy = ordy;
    #1;
    ch = md ? scan_pos : int'(s);
    exp_rdy = (exp_q.size() == 0 || ordy) && (md || int'(s) < N);
    check({tag, ".in_rdy"}, 32'(in_rdy), 32'(exp_rdy));
    acc = v && exp_rdy;
    if (ordy && exp_q.size() != 0) void'(exp_q.pop_front());
    if (acc) begin
      last_data = W'((in_data >> (ch * W)) & ((1 << W) - 1));
      last_ch = SW'(ch);
      exp_q.push_back({last_ch, last_data});
      if (md) scan_pos = (scan_pos + 1) % N;
    end
    if (!md && v && int'(s) >= N) exp_err = 1'b1;
    @(posedge clk);
    #1;
    check_outputs(tag);
  endtask

  task automatic ramp_data();
    for (int k = 0; k < N; k++) in_data[k*W +: W] = W'(8'h10 + k);
  endtask

  initial begin
    in_data = '0; in_vld = 0; sel = '0; mode = 0; out_rdy = 1; rst = 1;
    do_reset();

    // direct select sweep
    ramp_data();
    for (int k = 0; k < N; k++) step(1, 0, SW'(k), 1, "direct");
    check("direct.last_word", 32'(out_data), 32'h14);

    // out-of-range select refused
    do_reset();
    for (int i = 0; i < 3; i++) step(1, 0, SW'(6), 1, "oor");
    check("oor.out_vld_low", 32'(out_vld), 32'h0);

    // scan wrap-around
    do_reset();
    for (int i = 0; i < 7; i++) begin
      step(1, 1, '0, 1, "scan");
      check("scan.seq", 32'(cur_ch), 32'(i % N));
    end

    // backpressure then bubble-free restart
    do_reset();
    step(1, 0, SW'(2), 1, "bp.a");
    for (int i = 0; i < 4; i++) step(1, 0, SW'(3), 0, "bp.hold");
    check("bp.held_a", 32'(out_data), 32'h12);
    step(1, 0, SW'(3), 1, "bp.release");
    check("bp.no_bubble", 32'(out_data), 32'h13);

    // mode switching keeps scan position
    do_reset();
    step(1, 1, '0, 1, "sw.s0");
    step(1, 1, '0, 1, "sw.s1");
    step(1, 0, SW'(4), 1, "sw.d4");
    step(1, 1, '0, 1, "sw.s2");
    check("sw.scan_held", 32'(cur_ch), 32'd2);

    // reset mid-operation
    for (int i = 0; i < 1; i++) step(1, 1, '0, 1, "mid.s3");
    do_reset();
    step(1, 1, '0, 1, "mid.after");
    check("mid.scan_restart", 32'(cur_ch), 32'd0);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < N; k++) in_data[k*W +: W] = W'($urandom);
      if ($urandom_range(0, 99) == 0) do_reset();
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
           SW'($urandom_range(0, 7)), 1'($urandom_range(0, 2) != 0), "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/reg_mux_n.md
# reg_mux_n

Parametrised registered N:1 multiplexer with a one-deep valid/ready output stage and two channel-selection modes: direct (external select) and scan (internal round-robin counter). It is the generalised successor of the team's fixed 5-input registered mux. It adds configurable channel count and width, a defined response to out-of-range selects (no hold-on-last-value latching), and flow control for use between pipelined stages.

## Interface

- N, 5, number of input channels, legal range 2..16
- W, 1, data width per channel in bits
- SW, derived localparam, $clog2(N), select and channel-index width
- clk  input  1  single clock; all logic on its rising edge
- rst  input  1  reset, synchronous and active-high
- in_data  input  N*W  channel k occupies bits [k*W +: W]
- in_vld  input  1  input word valid
- in_rdy  output  1  stage can accept this cycle
- sel  input  SW  channel index, used when mode=0
- mode  input  1  0 = direct select, 1 = scan
- out_data  output  W  registered selected data
- out_vld  output  1  out_data holds an unconsumed word
- out_rdy  input  1  downstream accepts out_data
- cur_ch  output  SW  channel index that produced the current out_data
- sel_err  output  1  sticky out-of-range flag; present only with MUX_SEL_ERR_EN

## Operation

- space = !out_vld || out_rdy.
- Source channel: mode=0 uses sel; mode=1 uses internal scan_ch.
- sel_ok = (mode=1) || (sel < N).
- in_rdy = space && sel_ok. This is combinational from out_vld, out_rdy, mode, and sel, and does not depend on in_vld.
- Accept = in_vld && in_rdy. On accept: out_data <= selected channel, cur_ch <= source index, out_vld <= 1.
- No accept and out_rdy && out_vld: out_vld <= 0. out_data and cur_ch hold their values.
- No accept and no drain: all outputs hold.
- Out-of-range select (mode=0, sel >= N): no accept, in_rdy=0, and the output register is unchanged. This can only occur when N is not a power of 2.
- scan_ch: SW-bit counter.
  - Increments only on an accept made while mode=1.
  - Wraps from N-1 to 0.
  - Holds while mode=0.
  - Is not reset by mode changes.
- mode and sel may change on any cycle. They are sampled only on accepting cycles.

## Timing

- Reset values: out_data=0, out_vld=0, cur_ch=0, scan_ch=0, sel_err=0. in_rdy is therefore 1 in the first cycle after reset whenever sel_ok holds.
- Latency: a word accepted at edge t appears with out_vld=1 after edge t, i.e. one cycle.
- Throughput: one word per cycle. A simultaneous drain and accept replaces out_data without out_vld deasserting.
- Backpressure: out_vld=1 with out_rdy=0 holds out_data and cur_ch stable and forces in_rdy=0.
- Reset mid-operation: any held word is discarded and scan_ch returns to 0. rst has priority over accept.
- Wrap-around: with N=5 in mode=1, accepted words come from channels 0,1,2,3,4,0,...

## Configuration

- MUX_SEL_ERR_EN defined:
  - Port sel_err exists.
  - sel_err is set to 1 on the edge after any cycle with mode=0, in_vld=1 and sel >= N.
  - It stays at 1 until rst and does not affect datapath behaviour.
- MUX_SEL_ERR_EN undefined:
  - Port sel_err and its logic are absent.
  - Out-of-range selects are silently refused as described under Operation.

## Test plan

- N=5, W=8, mode=0, out_rdy=1; drive in_vld with sel=0..4 on consecutive cycles, channel k = 8'h10+k -> out_data 10,11,12,13,14 one cycle later each, cur_ch 0..4, out_vld continuously 1.
- N=5, mode=0, sel=6, in_vld=1 for 3 cycles -> in_rdy=0, out_vld stays 0, out_data unchanged; with MUX_SEL_ERR_EN, sel_err=1 from the second cycle and stays 1 until rst.
- N=5, mode=1, in_vld=1, out_rdy=1 for 7 cycles -> cur_ch sequence 0,1,2,3,4,0,1.
- Backpressure: accept word A, then hold out_rdy=0 for 4 cycles with in_vld=1 -> in_rdy=0, out_data=A stable; after releasing out_rdy, the next word follows in the next cycle with no bubble.
- Mode switching: mode=1 for 2 accepts, then mode=0 with sel=4 for 1 accept, then mode=1 -> cur_ch sequence 0,1,4,2 (scan_ch held at 2).
- Assert rst while out_vld=1 and scan_ch=3 -> next cycle out_vld=0, out_data=0, cur_ch=0, and the next scan accept comes from channel 0.
